// File: rtl/write_resp_merger.sv
`default_nettype none
// ============================================================================
// write_resp_merger: merges the AXI3 B responses of one split AXI4 write
// burst into a single AXI4 B response.  Rev 1.0
// ============================================================================
module write_resp_merger #(
   parameter int AXI4_Aw_len = 8,
   parameter int AXI3_Aw_len = 4,
   parameter int Cnt_width   = AXI4_Aw_len - AXI3_Aw_len + 1
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic                   Load_Expected,
   input  logic [AXI4_Aw_len-1:0] AXI4_Sel_S_AXI_awlen,
   output logic                   Busy,
   output logic [Cnt_width-1:0]   Outstanding,
   input  logic [1:0]             S_AXI3_bresp,
   input  logic                   S_AXI3_bvalid,
   output logic                   S_AXI3_bready,
   output logic [1:0]             M_AXI4_bresp,
   output logic                   M_AXI4_bvalid,
   input  logic                   M_AXI4_bready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t               state_q;
   logic [Cnt_width-1:0] outstanding_q;
   logic [1:0]           acc_q;
   logic                 allex_q;
   logic                 s_bready_q;
   logic                 m_bvalid_q;
   logic [1:0]           m_bresp_q;

   logic                 hs_d;
   logic [1:0]           sev_d;
   logic [1:0]           acc_d;
   logic [1:0]           merged_d;
   logic [Cnt_width-1:0] load_cnt_d;
   logic                 w_unused_lsbs;

   // Sub-burst count is awlen/2^AXI3_Aw_len + 1; the beat-index bits don't matter.
   assign load_cnt_d    = {1'b0, AXI4_Sel_S_AXI_awlen[AXI4_Aw_len-1:AXI3_Aw_len]} + Cnt_width'(1);
   assign w_unused_lsbs = ^AXI4_Sel_S_AXI_awlen[AXI3_Aw_len-1:0];

   assign hs_d     = S_AXI3_bvalid && s_bready_q;
   // EXOKAY ranks as OKAY; the remaining codes are ordered numerically.
   assign sev_d    = (S_AXI3_bresp == 2'b01) ? 2'b00 : S_AXI3_bresp;
   assign acc_d    = (sev_d > acc_q) ? sev_d : acc_q;
   assign merged_d = (allex_q && (S_AXI3_bresp == 2'b01)) ? 2'b01 : acc_d;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q       <= IDLE;
         outstanding_q <= '0;
         acc_q         <= 2'b00;
         allex_q       <= 1'b1;
         s_bready_q    <= 1'b0;
         m_bvalid_q    <= 1'b0;
         m_bresp_q     <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (Load_Expected) begin
                  outstanding_q <= load_cnt_d;
                  acc_q         <= 2'b00;
                  allex_q       <= 1'b1;
                  s_bready_q    <= 1'b1;
                  state_q       <= COLLECT;
               end
            end
            COLLECT: begin
               if (hs_d) begin
                  outstanding_q <= outstanding_q - Cnt_width'(1);
                  acc_q         <= acc_d;
                  allex_q       <= allex_q && (S_AXI3_bresp == 2'b01);
                  if (outstanding_q == Cnt_width'(1)) begin
                     s_bready_q <= 1'b0;
                     m_bvalid_q <= 1'b1;
                     m_bresp_q  <= merged_d;
                     state_q    <= RESPOND;
                  end
               end
            end
            RESPOND: begin
               if (M_AXI4_bready) begin
                  m_bvalid_q    <= 1'b0;
                  outstanding_q <= '0;
                  state_q       <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               s_bready_q <= 1'b0;
               m_bvalid_q <= 1'b0;
            end
         endcase
      end
   end

   assign Busy          = (state_q != IDLE);
   assign Outstanding   = outstanding_q;
   assign S_AXI3_bready = s_bready_q;
   assign M_AXI4_bvalid = m_bvalid_q;
   assign M_AXI4_bresp  = m_bresp_q;

endmodule
`default_nettype wire

// File: doc/write_resp_merger.md
Name: write_resp_merger

Overview:
- Write-response side of the AXI4-to-AXI3 burst splitter.
- The address-side splitter breaks one AXI4 write burst (awlen up to 255) into ceil((awlen+1)/16) AXI3 sub-bursts.
- This block accepts one AXI3 B response per sub-burst and merges them into a single AXI4 B response back to the original master.
- It sits between the AXI3 slave's B channel and the AXI4 master's B channel.

Parameters:
- AXI4_Aw_len, 8, width of the original AXI4 awlen.
- AXI3_Aw_len, 4, width of the AXI3 awlen; the sub-burst holds 2^AXI3_Aw_len beats.
- Cnt_width, AXI4_Aw_len-AXI3_Aw_len+1 (5), width of the outstanding-response counter.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; synchronous, active-low.
- Load_Expected  in  1  single-cycle pulse when the original AXI4 AW is accepted (same cycle the splitter loads).
- AXI4_Sel_S_AXI_awlen  in  AXI4_Aw_len  original burst length; sampled on Load_Expected.
- Busy  out  1  merge in progress (COLLECT or RESPOND).
- Outstanding  out  Cnt_width  sub-responses still expected.
- S_AXI3_bresp  in  2  sub-burst response from the AXI3 slave.
- S_AXI3_bvalid  in  1  sub-burst response valid.
- S_AXI3_bready  out  1  sub-burst response accept.
- M_AXI4_bresp  out  2  merged response to the AXI4 master.
- M_AXI4_bvalid  out  1  merged response valid.
- M_AXI4_bready  in  1  master accepts the merged response.

Behaviour:
- The clock is ACLK. Reset is ARESETN, synchronous and active-low: all state is sampled on the ACLK rising edge.
- Reset values: state=IDLE, Busy=0, Outstanding=0, S_AXI3_bready=0, M_AXI4_bvalid=0, M_AXI4_bresp=00, merge accumulator=OKAY with the all-EXOKAY flag set.
- Reset asserted mid-operation aborts the merge and returns to IDLE the next edge. Partially collected responses are discarded.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- State IDLE:
  - S_AXI3_bready=0, M_AXI4_bvalid=0.
  - On Load_Expected: Outstanding <= (awlen >> AXI3_Aw_len) + 1 (1..16), accumulator <= OKAY, all-EXOKAY flag <= 1, go to COLLECT.
  - S_AXI3_bvalid in IDLE is not accepted and has no effect.
- State COLLECT:
  - S_AXI3_bready=1. This gives 1-cycle latency: Load_Expected at edge L puts bready high after L.
  - Each handshake (bvalid && bready): Outstanding decrements by 1.
  - Each handshake: accumulator <= max severity of accumulator and the incoming response. Severity order is DECERR(11) > SLVERR(10) > OKAY(00); EXOKAY(01) counts as OKAY.
  - Each handshake: if bresp != 01, clear the all-EXOKAY flag.
  - Back-to-back handshakes are accepted every cycle.
  - Handshake while Outstanding==1: go to RESPOND.
  - M_AXI4_bresp <= merged value including the current response. The merged value is 01 if the all-EXOKAY flag is still set and bresp==01; otherwise it is the severity result.
  - M_AXI4_bvalid is high on the next cycle, so the last sub-handshake at edge N gives M_AXI4_bvalid from N onward.
  - S_AXI3_bready drops in the same transition, so no extra sub-response is taken.
- State RESPOND:
  - M_AXI4_bvalid=1 and M_AXI4_bresp are held stable until M_AXI4_bready; S_AXI3_bready=0.
  - On M_AXI4_bready: bvalid drops next cycle, Outstanding=0, go to IDLE.
- Busy=1 in COLLECT and RESPOND. Load_Expected while Busy=1 is ignored, including the cycle of the final M_AXI4_bready. The upstream block must gate loads with Busy.
- Outstanding never underflows: decrements occur only in COLLECT, and COLLECT exits at 1→0.
- Minimum turnaround: IDLE→IDLE is 3 cycles (load, one sub-response, master accept).

Test Plan:
- awlen=0: Load_Expected, then one S bresp=00 → Outstanding 1→0, M_AXI4_bvalid=1 with bresp=00 on the next cycle. After M_AXI4_bready, Busy=0 and state=IDLE.
- awlen=255 with S_AXI3_bvalid held high: exactly 16 handshakes, Outstanding counts 16→0. M_AXI4_bvalid rises after the 16th handshake and S_AXI3_bready=0 from then on; the 17th offered response is not accepted.
- awlen=40 (3 sub-bursts): responses 00,10,00 → M_AXI4_bresp=10. Responses 11,10,00 → 11. Responses 01,00,01 → 00.
- awlen=31 with responses 01,01 → M_AXI4_bresp=01. With random gaps of 0–4 cycles between bvalid pulses, the result is unchanged.
- Backpressure: M_AXI4_bready held low for 5 cycles → M_AXI4_bvalid/bresp stable, S_AXI3_bready=0, Busy=1. A Load_Expected pulse in that window is ignored (Outstanding unchanged).
- ARESETN low for 1 cycle after 2 of 4 sub-responses → next cycle all outputs at reset values. A following awlen=15 transaction completes normally with one sub-response.
